// File: rtl/regfile_bank.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bank
// Summary  : Parametrised multi-read-port register file for the single-cycle
//            RISC-V datapath. After reset a hardware sequence clears every
//            entry and then raises ready. Writes attempted while clearing
//            are dropped and set the sticky wr_err flag. Read ports are
//            combinational. A registered debug port allows observation.
// Options  : REGFILE_BANK_BYPASS_EN - write-to-read forwarding on the
//            combinational read ports (the debug port is never forwarded).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_bank #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    input  logic [AW-1:0]        dbg_addr,
    output logic [WIDTH-1:0]     dbg_data,
    output logic                 ready,
    output logic                 wr_err,
    input  logic                 wr_err_clr
);

    // Index of the final entry; reaching it ends the clear sweep.
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_zero_idx = '0;
    localparam logic [AW-1:0] c_ptr_inc  = AW'(1);
    // Register 0 behaves as a hardwired zero when this is set.
    localparam bit            c_zero_en  = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_clr_ptr;
    logic [AW-1:0]      w_clr_ptr_next;

    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               r_wr_err;
    logic [WIDTH-1:0]   r_dbg_data;

    logic               w_run;
    logic               w_mem_we;
    logic [AW-1:0]      w_mem_addr;
    logic [WIDTH-1:0]   w_mem_wdata;
    logic               w_waddr_is_zero;
    logic               w_dbg_mask;
    logic [WIDTH-1:0]   w_dbg_value;

    assign w_run           = (r_state == ST_RUN);
    assign w_waddr_is_zero = c_zero_en && (waddr == c_zero_idx);

    // State and clear-pointer register; reset restarts the sweep at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    // Next-state logic: CLEAR walks every entry once, then RUN holds until reset.
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_next = r_clr_ptr + c_ptr_inc;
                if (r_clr_ptr == c_last_idx) begin
                    w_state_next   = ST_RUN;
                    w_clr_ptr_next = '0;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next   = ST_CLEAR;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    // Single array write port, shared between the clear sweep and user writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = waddr;
        w_mem_wdata = wdata;
        if (!w_run) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr;
            w_mem_wdata = '0;
        end else if (we && !w_waddr_is_zero) begin
            w_mem_we    = 1'b1;
        end
    end

    // Storage array; deliberately not reset, the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Sticky error: a write while not ready sets it, and setting beats clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else if (!w_run && we) begin
            r_wr_err <= 1'b1;
        end else if (wr_err_clr) begin
            r_wr_err <= 1'b0;
        end
    end

    assign w_dbg_mask  = !w_run || (c_zero_en && (dbg_addr == c_zero_idx));
    assign w_dbg_value = w_dbg_mask ? '0 : r_mem[dbg_addr];

    // Debug port samples the pre-write array contents, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= w_dbg_value;
        end
    end

    // Combinational read ports, with the same zero masking as the debug port.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_mask;

            assign w_addr = raddr[k*AW +: AW];
            assign w_mask = !w_run || (c_zero_en && (w_addr == c_zero_idx));

`ifdef REGFILE_BANK_BYPASS_EN
            // Forward the in-flight write so the reader sees it this cycle.
            logic          w_hit;
            assign w_hit = w_run && we && (w_addr == waddr);
            assign rdata[k*WIDTH +: WIDTH] = w_mask ? '0 :
                                             (w_hit ? wdata : r_mem[w_addr]);
`else
            assign rdata[k*WIDTH +: WIDTH] = w_mask ? '0 : r_mem[w_addr];
`endif
        end
    endgenerate

    assign ready    = w_run;
    assign wr_err   = r_wr_err;
    assign dbg_data = r_dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_bank
// Summary  : Directed self-checking bench for regfile_bank. Two instances
//            share all inputs: dut_z (ZERO_REG=1) and dut_n (ZERO_REG=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_bank;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                 clk        = 1'b0;
    logic                 rst_n      = 1'b0;
    logic                 we         = 1'b0;
    logic [AW-1:0]        waddr      = '0;
    logic [WIDTH-1:0]     wdata      = '0;
    logic [NRD*AW-1:0]    raddr      = '0;
    logic [AW-1:0]        dbg_addr   = '0;
    logic                 wr_err_clr = 1'b0;

    logic [NRD*WIDTH-1:0] rdata_z;
    logic [WIDTH-1:0]     dbg_data_z;
    logic                 ready_z;
    logic                 wr_err_z;
    logic [NRD*WIDTH-1:0] rdata_n;
    logic [WIDTH-1:0]     dbg_data_n;
    logic                 ready_n;
    logic                 wr_err_n;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_bank #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)
    ) dut_z (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_z), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data_z), .ready(ready_z), .wr_err(wr_err_z),
        .wr_err_clr(wr_err_clr)
    );

    regfile_bank #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(0)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data_n), .ready(ready_n), .wr_err(wr_err_n),
        .wr_err_clr(wr_err_clr)
    );

    always #5 clk = ~clk;

    // Count rising edges until ready, bounded so a stuck FSM cannot hang.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready_z !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // One-cycle write pulse, returns on the negedge after the write edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        @(negedge clk);
        n_checks++;
        if (ready_z !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_z);
        end
        n_checks++;
        if (wr_err_z !== 1'b0) begin
            n_fail++; $display("FAIL reset_wr_err: got %b expected 0", wr_err_z);
        end
        n_checks++;
        if (dbg_data_z !== 32'h0) begin
            n_fail++; $display("FAIL reset_dbg_data: got %h expected 0", dbg_data_z);
        end
        rst_n = 1'b1;
        wait_ready(cyc);
        n_checks++;
        if (cyc != 32) begin
            n_fail++; $display("FAIL clear_length: got %0d cycles expected 32", cyc);
        end
        n_checks++;
        if (ready_n !== 1'b1) begin
            n_fail++; $display("FAIL clear_ready_n: got %b expected 1", ready_n);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEADBEEF);
        raddr    = {5'd0, 5'd5};
        dbg_addr = 5'd5;
        #1;
        n_checks++;
        if (rdata_z[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_rd_port0: got %h expected deadbeef", rdata_z[31:0]);
        end
        n_checks++;
        if (dbg_data_z !== 32'h0) begin
            n_fail++; $display("FAIL dbg_latency: got %h expected 0", dbg_data_z);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_data_z !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dbg_read: got %h expected deadbeef", dbg_data_z);
        end
        raddr = {5'd5, 5'd5};
        #1;
        n_checks++;
        if (rdata_z[63:32] !== 32'hDEADBEEF || rdata_z[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alias_ports: got %h expected deadbeefdeadbeef", rdata_z);
        end
        n_checks++;
        if (wr_err_z !== 1'b0) begin
            n_fail++; $display("FAIL run_write_no_err: got %b expected 0", wr_err_z);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'h12345678);
        raddr    = {5'd0, 5'd0};
        dbg_addr = 5'd0;
        #1;
        n_checks++;
        if (rdata_z[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_z: got %h expected 0", rdata_z[31:0]);
        end
        n_checks++;
        if (rdata_n[31:0] !== 32'h12345678) begin
            n_fail++; $display("FAIL zero_reg_n: got %h expected 12345678", rdata_n[31:0]);
        end
        n_checks++;
        if (wr_err_z !== 1'b0) begin
            n_fail++; $display("FAIL zero_reg_err: got %b expected 0", wr_err_z);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_data_z !== 32'h0 || dbg_data_n !== 32'h12345678) begin
            n_fail++; $display("FAIL zero_reg_dbg: got %h/%h expected 0/12345678",
                               dbg_data_z, dbg_data_n);
        end
    endtask

    task automatic test_hazard();
        logic [WIDTH-1:0] exp_same;
`ifdef REGFILE_BANK_BYPASS_EN
        exp_same = 32'h22;
`else
        exp_same = 32'h11;
`endif
        do_write(5'd7, 32'h11);
        we       = 1'b1;
        waddr    = 5'd7;
        wdata    = 32'h22;
        raddr    = {5'd7, 5'd0};
        dbg_addr = 5'd7;
        #1;
        n_checks++;
        if (rdata_z[63:32] !== exp_same) begin
            n_fail++; $display("FAIL hazard_same_cycle: got %h expected %h", rdata_z[63:32], exp_same);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_data_z !== 32'h11) begin
            n_fail++; $display("FAIL hazard_dbg_old: got %h expected 11", dbg_data_z);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata_z[63:32] !== 32'h22) begin
            n_fail++; $display("FAIL hazard_next_cycle: got %h expected 22", rdata_z[63:32]);
        end
    endtask

    task automatic test_mid_run_reset();
        int cyc;
        for (int a = 0; a < DEPTH; a++) begin
            do_write(AW'(a), 32'hA5A50000 | a);
        end
        do_write(5'd9, 32'h55);
        raddr = {5'd31, 5'd9};
        #1;
        n_checks++;
        if (rdata_z[31:0] !== 32'h55 || rdata_z[63:32] !== 32'hA5A5001F) begin
            n_fail++; $display("FAIL fill_read: got %h expected a5a5001f00000055", rdata_z);
        end
        raddr = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (rdata_n[31:0] !== 32'hA5A50000) begin
            n_fail++; $display("FAIL fill_entry0_n: got %h expected a5a50000", rdata_n[31:0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        raddr = {5'd31, 5'd9};
        #1;
        n_checks++;
        if (ready_z !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ready: got %b expected 0", ready_z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rdata_z[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL clear_masked_read: got %h expected 0", rdata_z[63:32]);
        end
        wait_ready(cyc);
        n_checks++;
        if (cyc != 32) begin
            n_fail++; $display("FAIL reclear_length: got %0d cycles expected 32", cyc);
        end
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            n_checks++;
            if (rdata_z !== 64'h0 || rdata_n !== 64'h0) begin
                n_fail++; $display("FAIL reclear_entry%0d: got %h/%h expected 0", a, rdata_z, rdata_n);
            end
        end
    endtask

    task automatic test_write_during_clear();
        int cyc;
        do_write(5'd3, 32'h77);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'hAA;
        #1;
        n_checks++;
        if (wr_err_z !== 1'b0) begin
            n_fail++; $display("FAIL clear_err_before: got %b expected 0", wr_err_z);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_err_z !== 1'b1 || wr_err_n !== 1'b1) begin
            n_fail++; $display("FAIL clear_err_set: got %b/%b expected 1/1", wr_err_z, wr_err_n);
        end
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        we         = 1'b1;
        wr_err_clr = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_err_z !== 1'b1) begin
            n_fail++; $display("FAIL err_set_priority: got %b expected 1", wr_err_z);
        end
        @(negedge clk);
        we         = 1'b0;
        wr_err_clr = 1'b0;
        wait_ready(cyc);
        n_checks++;
        if (cyc != 26) begin
            n_fail++; $display("FAIL clear_remaining: got %0d cycles expected 26", cyc);
        end
        raddr = {5'd0, 5'd3};
        #1;
        n_checks++;
        if (rdata_z[31:0] !== 32'h0 || rdata_n[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL clear_write_dropped: got %h/%h expected 0", rdata_z[31:0], rdata_n[31:0]);
        end
        n_checks++;
        if (wr_err_z !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b expected 1", wr_err_z);
        end
        @(negedge clk);
        wr_err_clr = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_err_z !== 1'b0 || wr_err_n !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b/%b expected 0/0", wr_err_z, wr_err_n);
        end
        @(negedge clk);
        wr_err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_hazard();
        test_mid_run_reset();
        test_write_during_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised register file for the single-cycle RISC-V datapath, successor to the fixed 32x32 file.
- Configurable width, depth and number of read ports, with an optional hardwired-zero register 0.
- Hardware clear sequence after reset, with a ready flag.
- Sticky error flag for writes rejected during clear.
- Registered debug/observation read port.
- Sits between decode (rs1/rs2/rd fields) and ALU/writeback.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), address width; derived, do not override.
- NRD, 2, number of combinational read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr  in  NRD*AW  packed read addresses; port k is bits [k*AW +: AW].
- rdata  out  NRD*WIDTH  packed read data; port k is bits [k*WIDTH +: WIDTH].
- dbg_addr  in  AW  debug read address.
- dbg_data  out  WIDTH  registered debug read data.
- ready  out  1  1 = clear sequence done, file usable.
- wr_err  out  1  sticky; a write was attempted while ready=0.
- wr_err_clr  in  1  synchronous clear of wr_err.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to CLEAR, clr_ptr=0.
  - ready=0, wr_err=0, dbg_data=0.
  - Array contents are not reset directly.
- FSM state CLEAR:
  - Each cycle writes 0 to entry clr_ptr, then clr_ptr++.
  - When clr_ptr==DEPTH-1 is written, go to RUN next cycle and set ready=1.
  - CLEAR lasts exactly DEPTH cycles after rst_n rises.
- FSM state RUN:
  - Stays in RUN until the next reset.
  - Asserting rst_n=0 mid-operation restarts CLEAR from entry 0.
- Write:
  - In RUN, when we=1, entry waddr <= wdata on the clk edge.
  - If ZERO_REG=1 and waddr==0, the write is discarded; no error.
  - In CLEAR, a write with we=1 is discarded and wr_err is set next cycle.
- wr_err:
  - wr_err_clr=1 clears it next cycle.
  - Set has priority over clear in the same cycle.
- Read ports (combinational, 0 latency):
  - rdata[k] = entry raddr[k].
  - Forced to 0 if ZERO_REG=1 and raddr[k]==0.
  - Forced to 0 while ready=0.
- Same-cycle write/read to the same address: without bypass, the read returns the old value; the new value is visible the cycle after the edge.
- Debug port:
  - dbg_data <= entry dbg_addr each cycle, 1-cycle latency.
  - Same zero rules as the read ports.
  - Reads the pre-write value when written in the same cycle.
- Address range: waddr, raddr and dbg_addr are always in range because DEPTH = 2^AW; there is no out-of-range case.
- Simultaneous read ports may alias the same address; each returns identical data.

Optional Feature:
- Macro: REGFILE_BANK_BYPASS_EN.
- Defined:
  - Write-to-read forwarding on every read port.
  - If RUN and we=1 and raddr[k]==waddr, and the address is not the zero register when ZERO_REG=1, then rdata[k]=wdata in the same cycle.
  - The debug port is not bypassed.
- Not defined: no forwarding logic is present; reads return the stored (old) value as above.

Test Plan:
- Reset and clear, DEPTH=32:
  - Release rst_n → ready=0 for exactly 32 cycles, then 1.
  - All 32 entries then read 0 on both ports.
- Write/read:
  - In RUN, write waddr=5, wdata=0xDEADBEEF.
  - Next cycle raddr0=5 → rdata0=0xDEADBEEF.
  - dbg_addr=5 → dbg_data=0xDEADBEEF one cycle later.
- Zero register:
  - With ZERO_REG=1, write waddr=0, wdata=0x12345678 → raddr=0 reads 0, wr_err stays 0.
  - With ZERO_REG=0, the same reads 0x12345678.
- Write during CLEAR:
  - we=1, waddr=3, wdata=0xAA at cycle 4 of CLEAR → wr_err=1 next cycle.
  - Entry 3 reads 0 after ready.
  - wr_err_clr pulse → wr_err=0.
- Same-cycle hazard:
  - Entry 7 holds 0x11; write 0x22 to 7 while raddr1=7.
  - Same cycle rdata1 = 0x11 without REGFILE_BANK_BYPASS_EN, 0x22 with it.
  - Next cycle 0x22 in both builds.
- Mid-run reset:
  - After writing 0x55 to entry 9, pulse rst_n low for 1 cycle → ready drops at once.
  - After the re-clear, entry 9 reads 0.
